// File: rtl/k_matrix_loader.sv
// rtl/k_matrix_loader.sv - writable RLS gain matrix K, loaded one coefficient per cycle.
// Define KLOAD_CHECKSUM_EN to add the checksum port (modular sum of accepted words).
`timescale 1ns/1ps
module k_matrix_loader #(
   parameter int nBits = 32,
   parameter int M     = 32,
   parameter int N     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [nBits-1:0]         in_data,
   output logic [M*N*nBits-1:0]     K,
   output logic                     loaded,
   output logic                     busy,
   output logic [$clog2(M*N+1)-1:0] count
`ifdef KLOAD_CHECKSUM_EN
   ,output logic [nBits-1:0]        checksum
`endif
);
   localparam int MN = M * N;
   localparam int CW = $clog2(MN + 1);
   localparam int IW = (MN > 1) ? $clog2(MN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [nBits-1:0]  k_q [MN];
   logic              xfer;
   logic [IW-1:0]     wr_idx;

   assign wr_idx = count_q[IW-1:0];
   assign count  = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // start wins over a coincident transfer: the word is dropped and the load restarts.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      loaded   = 1'b0;
      xfer     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               count_d = '0;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (start) begin
               count_d = '0;
            end else if (in_valid) begin
               xfer    = 1'b1;
               count_d = count_q + CW'(1);
               if (count_q == CW'(MN - 1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            loaded = 1'b1;
            if (start) begin
               state_d = S_LOAD;
               count_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MN; i++) k_q[i] <= '0;
      end else if (xfer) begin
         k_q[wr_idx] <= in_data;
      end
   end

   // Word 0 occupies the most significant slice, matching the constant block's concatenation.
   always_comb begin
      K = '0;
      for (int i = 0; i < MN; i++) K[(MN-i)*nBits-1 -: nBits] = k_q[i];
   end

`ifdef KLOAD_CHECKSUM_EN
   logic [nBits-1:0] sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     sum_q <= '0;
      else if (start) sum_q <= '0;
      else if (xfer)  sum_q <= sum_q + in_data;
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_k_matrix_loader.sv
// tb/tb_k_matrix_loader.sv - self-checking bench for k_matrix_loader (2x2 and default 32x16 instances).
`timescale 1ns/1ps
module tb_k_matrix_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         s_start = 0, s_valid = 0, s_ready, s_loaded, s_busy;
   logic [31:0]  s_data = 0;
   logic [127:0] s_k;
   logic [2:0]   s_count;
   logic         b_start = 0, b_valid = 0, b_ready, b_loaded, b_busy;
   logic [31:0]  b_data = 0;
   logic [16383:0] b_k;
   logic [9:0]   b_count;
`ifdef KLOAD_CHECKSUM_EN
   logic [31:0]  s_sum, b_sum;
`endif

   int checks = 0;
   int failures = 0;
   logic [31:0] sm [4];
   logic [31:0] bm [512];

   k_matrix_loader #(.nBits(32), .M(2), .N(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
      .in_data(s_data), .K(s_k), .loaded(s_loaded), .busy(s_busy), .count(s_count)
`ifdef KLOAD_CHECKSUM_EN
      , .checksum(s_sum)
`endif
   );

   k_matrix_loader u_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
      .in_data(b_data), .K(b_k), .loaded(b_loaded), .busy(b_busy), .count(b_count)
`ifdef KLOAD_CHECKSUM_EN
      , .checksum(b_sum)
`endif
   );

   // Expected K: concatenation of the words in arrival order, first word most significant.
   function automatic logic [127:0] pack_small();
      logic [127:0] r = '0;
      for (int i = 0; i < 4; i++) r = {r[95:0], sm[i]};
      return r;
   endfunction

   function automatic logic [16383:0] pack_big();
      logic [16383:0] r = '0;
      for (int i = 0; i < 512; i++) r = (r << 32) | 16384'(bm[i]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (s_k !== 128'h0) begin failures++; $display("FAIL reset_k got=%h exp=0", s_k); end
      checks++; if (s_loaded !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b0) begin failures++;
         $display("FAIL reset_flags got loaded=%b busy=%b ready=%b exp 0 0 0", s_loaded, s_busy, s_ready); end
      checks++; if (s_count !== 3'd0 || b_count !== 10'd0) begin failures++;
         $display("FAIL reset_count got=%0d/%0d exp=0", s_count, b_count); end
      checks++; if (b_k !== '0 || b_ready !== 1'b0) begin failures++; $display("FAIL reset_big got ready=%b exp 0 and K=0", b_ready); end
`ifdef KLOAD_CHECKSUM_EN
      checks++; if (s_sum !== 32'h0 || b_sum !== 32'h0) begin failures++; $display("FAIL reset_checksum got=%h/%h exp=0", s_sum, b_sum); end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reject(input string tag, input logic [2:0] exp_count);
      int bad = 0;
      s_valid = 1'b1;
      s_data  = 32'hdeadbeef;
      for (int i = 0; i < 3; i++) begin
         if (s_ready !== 1'b0) bad++;
         tick();
      end
      s_valid = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL %s_ready got %0d cycles ready exp 0", tag, bad); end
      checks++; if (s_k !== pack_small()) begin failures++; $display("FAIL %s_k got=%h exp=%h", tag, s_k, pack_small()); end
      checks++; if (s_count !== exp_count) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, s_count, exp_count); end
   endtask

   task automatic test_basic();
      logic [31:0] w [4] = '{32'h00000156, 32'hffffff0e, 32'h000001a9, 32'h0000004b};
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checks++; if (s_ready !== 1'b1 || s_busy !== 1'b1 || s_loaded !== 1'b0 || s_count !== 3'd0) begin failures++;
         $display("FAIL basic_enter got ready=%b busy=%b loaded=%b count=%0d exp 1 1 0 0", s_ready, s_busy, s_loaded, s_count); end
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = w[i];
         sm[i]   = w[i];
         tick();
      end
      s_valid = 1'b0;
      checks++; if (s_k !== 128'h00000156_ffffff0e_000001a9_0000004b) begin failures++;
         $display("FAIL basic_k got=%h exp=00000156ffffff0e000001a90000004b", s_k); end
      checks++; if (s_loaded !== 1'b1 || s_busy !== 1'b0 || s_ready !== 1'b0 || s_count !== 3'd4) begin failures++;
         $display("FAIL basic_done got loaded=%b busy=%b ready=%b count=%0d exp 1 0 0 4", s_loaded, s_busy, s_ready, s_count); end
   endtask

   task automatic test_restart();
      int early = 0;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         sm[i]   = s_data;
         tick();
      end
      s_start = 1'b1;
      s_valid = 1'b1;
      s_data  = $urandom;
      tick();
      s_start = 1'b0;
      checks++; if (s_count !== 3'd0 || s_loaded !== 1'b0 || s_busy !== 1'b1) begin failures++;
         $display("FAIL restart_state got count=%0d loaded=%b busy=%b exp 0 0 1", s_count, s_loaded, s_busy); end
      checks++; if (s_k !== pack_small()) begin failures++; $display("FAIL restart_drop got=%h exp=%h", s_k, pack_small()); end
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         sm[i]   = s_data;
         if (s_loaded !== 1'b0) early++;
         tick();
      end
      s_valid = 1'b0;
      checks++; if (early != 0) begin failures++; $display("FAIL restart_early_loaded got %0d cycles exp 0", early); end
      checks++; if (s_k !== pack_small() || s_loaded !== 1'b1) begin failures++;
         $display("FAIL restart_k got=%h loaded=%b exp=%h loaded=1", s_k, s_loaded, pack_small()); end
   endtask

   task automatic test_big_stream();
      int xfers = 0, cyc = 0, cnt_bad = 0, extra = 0, first = -1;
      logic [16383:0] exp;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      while (xfers < 512 && cyc < 4000) begin
         b_valid = ($urandom_range(0, 3) != 0);
         b_data  = $urandom;
         @(negedge clk);
         if (b_count !== 10'(xfers)) cnt_bad++;
         if (b_valid && b_ready) begin
            bm[xfers] = b_data;
            xfers++;
         end
         tick();
         cyc++;
      end
      checks++; if (xfers != 512) begin failures++; $display("FAIL big_budget got %0d transfers exp 512", xfers); end
      checks++; if (cnt_bad != 0) begin failures++; $display("FAIL big_count_track got %0d bad cycles exp 0", cnt_bad); end
      b_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (b_ready) extra++;
         tick();
      end
      b_valid = 1'b0;
      checks++; if (extra != 0) begin failures++; $display("FAIL big_extra got %0d extra transfers exp 0", extra); end
      checks++; if (b_count !== 10'd512 || b_loaded !== 1'b1) begin failures++;
         $display("FAIL big_done got count=%0d loaded=%b exp 512 1", b_count, b_loaded); end
      exp = pack_big();
      for (int i = 0; i < 512; i++)
         if (first < 0 && b_k[16383-32*i -: 32] !== exp[16383-32*i -: 32]) first = i;
      checks++; if (b_k !== exp) begin failures++;
         $display("FAIL big_k first bad word %0d got=%h exp=%h", first, b_k[16383-32*first -: 32], exp[16383-32*first -: 32]); end
   endtask

`ifdef KLOAD_CHECKSUM_EN
   task automatic test_checksum();
      logic [31:0] w [4] = '{32'hffffffff, 32'h00000002, 32'h00000010, 32'h00000000};
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checks++; if (s_sum !== 32'h0) begin failures++; $display("FAIL checksum_clear got=%h exp=0", s_sum); end
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = w[i];
         sm[i]   = w[i];
         tick();
      end
      s_valid = 1'b0;
      tick();
      checks++; if (s_sum !== 32'h00000011) begin failures++; $display("FAIL checksum_sum got=%h exp=00000011", s_sum); end
   endtask
`endif

   task automatic test_async_reset();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = $urandom | 32'h1;
         sm[i]   = s_data;
         tick();
      end
      checks++; if (s_k !== pack_small()) begin failures++; $display("FAIL async_pre_k got=%h exp=%h", s_k, pack_small()); end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) sm[i] = '0;
      checks++; if (s_k !== 128'h0 || s_loaded !== 1'b0 || s_ready !== 1'b0) begin failures++;
         $display("FAIL async_reset got K=%h loaded=%b ready=%b exp 0 0 0", s_k, s_loaded, s_ready); end
      checks++; if (s_count !== 3'd0 || s_busy !== 1'b0) begin failures++;
         $display("FAIL async_reset_count got count=%0d busy=%b exp 0 0", s_count, s_busy); end
      s_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) sm[i] = '0;
      for (int i = 0; i < 512; i++) bm[i] = '0;
      test_reset();
      test_reject("idle_reject", 3'd0);
      test_basic();
      test_reject("done_reject", 3'd4);
      test_restart();
      test_big_stream();
`ifdef KLOAD_CHECKSUM_EN
      test_checksum();
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
